// File: rtl/sobel_grad_pkg.sv
// Shared types, constants and helpers for the streaming Sobel gradient block.
package sobel_grad_pkg;

    localparam int PIXEL_WIDTH_DEFAULT = 8;

    // Sobel kernels weight the centre tap by two; done as a left shift.
    localparam int SOBEL_CENTRE_SHIFT = 1;

    // Number of pixel columns kept in registers; the third column is the live one.
    localparam int WINDOW_STORED_COLS = 2;

    typedef logic [PIXEL_WIDTH_DEFAULT-1:0]       pixel_t;
    typedef logic signed [PIXEL_WIDTH_DEFAULT+2:0] grad_t;

    // A three-tap 1-2-1 sum needs two extra bits, and the signed difference one more.
    function automatic int grad_width(input int pixel_width);
        return pixel_width + 3;
    endfunction

endpackage

// File: rtl/sobel_grad_if.sv
// Pixel-in / gradient-out stream bundle with valid/ready handshakes on both sides.
interface sobel_grad_if #(
    parameter int PixelWidth = 8
);

    localparam int GradWidth = sobel_grad_pkg::grad_width(PixelWidth);

    logic                        valid_i;
    logic [PixelWidth-1:0]       pixel_i;
    logic                        ready_o;
    logic                        valid_o;
    logic signed [GradWidth-1:0] gx_o;
    logic signed [GradWidth-1:0] gy_o;
    logic                        ready_i;

    modport slave (
        input  valid_i, pixel_i, ready_i,
        output ready_o, valid_o, gx_o, gy_o
    );

    modport master (
        output valid_i, pixel_i, ready_i,
        input  ready_o, valid_o, gx_o, gy_o
    );

endinterface

// File: rtl/sobel_grad_line_buffer.sv
// Single-port line memory: one write and one unregistered read at the same column address.
module sobel_grad_line_buffer #(
    parameter int Width     = 16,
    parameter int Depth     = 640,
    parameter int AddrWidth = $clog2(Depth)
) (
    input  logic                 clk,
    input  logic [AddrWidth-1:0] addr,
    input  logic                 wr_en,
    input  logic [Width-1:0]     wr_data,
    output logic [Width-1:0]     rd_data
);

    logic [Width-1:0] mem [Depth];

    // Contents are never reset; rows are only read after they have been written this frame.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[addr] <= wr_data;
        end
    end

    assign rd_data = mem[addr];

endmodule

// File: rtl/sobel_grad.sv
// Streaming 3x3 Sobel gradient: raster pixels in, registered signed (gx, gy) out.
module sobel_grad
    import sobel_grad_pkg::*;
#(
    parameter int PixelWidth = 8,
    parameter int ImgWidth   = 640,
    parameter int ImgHeight  = 480
) (
    input logic        clk_i,
    input logic        rst_ni,
    sobel_grad_if.slave bus
);

    localparam int GradWidth = grad_width(PixelWidth);
    localparam int SumWidth  = PixelWidth + 2;
    localparam int ColWidth  = $clog2(ImgWidth);
    localparam int RowWidth  = $clog2(ImgHeight);

    logic [ColWidth-1:0] col;
    logic [RowWidth-1:0] row;

    // Two stored columns of the window; the newest (right) column is formed live from
    // the line buffers and the incoming pixel, so the oldest column is simply dropped.
    logic [PixelWidth-1:0] win [3][WINDOW_STORED_COLS];

    logic [2*PixelWidth-1:0] lb_rd;
    logic [2*PixelWidth-1:0] lb_wr;
    logic [PixelWidth-1:0]   above_two;
    logic [PixelWidth-1:0]   above_one;

    logic accept;
    logic out_cond;

    logic [SumWidth-1:0]         gx_left;
    logic [SumWidth-1:0]         gx_right;
    logic [SumWidth-1:0]         gy_top;
    logic [SumWidth-1:0]         gy_bottom;
    logic signed [GradWidth-1:0] gx_next;
    logic signed [GradWidth-1:0] gy_next;

    logic                        valid_q;
    logic signed [GradWidth-1:0] gx_q;
    logic signed [GradWidth-1:0] gy_q;

    // Upper half holds the row two above, lower half the row directly above.
    sobel_grad_line_buffer #(
        .Width (2 * PixelWidth),
        .Depth (ImgWidth)
    ) u_line_buffer (
        .clk     (clk_i),
        .addr    (col),
        .wr_en   (accept),
        .wr_data (lb_wr),
        .rd_data (lb_rd)
    );

    assign above_two = lb_rd[2*PixelWidth-1:PixelWidth];
    assign above_one = lb_rd[PixelWidth-1:0];
    assign lb_wr     = {above_one, bus.pixel_i};

    assign bus.ready_o = !valid_q || bus.ready_i;
    assign accept      = bus.valid_i && bus.ready_o;
    assign out_cond    = (row >= RowWidth'(2)) && (col >= ColWidth'(2));

    // Raster position of the pixel being accepted; wraps per line and per frame.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            col <= '0;
            row <= '0;
        end else if (accept) begin
            if (col == ColWidth'(ImgWidth - 1)) begin
                col <= '0;
                if (row == RowWidth'(ImgHeight - 1)) begin
                    row <= '0;
                end else begin
                    row <= row + RowWidth'(1);
                end
            end else begin
                col <= col + ColWidth'(1);
            end
        end
    end

    // Slide the window one column left on every accepted pixel, including across line wraps.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int r = 0; r < 3; r++) begin
                for (int c = 0; c < WINDOW_STORED_COLS; c++) begin
                    win[r][c] <= '0;
                end
            end
        end else if (accept) begin
            for (int r = 0; r < 3; r++) begin
                win[r][0] <= win[r][1];
            end
            win[0][1] <= above_two;
            win[1][1] <= above_one;
            win[2][1] <= bus.pixel_i;
        end
    end

    // Gradients of the window as it will look after this accept (stored cols + live column).
    always_comb begin
        gx_left   = SumWidth'(win[0][0])
                  + (SumWidth'(win[1][0]) << SOBEL_CENTRE_SHIFT)
                  + SumWidth'(win[2][0]);
        gx_right  = SumWidth'(above_two)
                  + (SumWidth'(above_one) << SOBEL_CENTRE_SHIFT)
                  + SumWidth'(bus.pixel_i);
        gy_top    = SumWidth'(win[0][0])
                  + (SumWidth'(win[0][1]) << SOBEL_CENTRE_SHIFT)
                  + SumWidth'(above_two);
        gy_bottom = SumWidth'(win[2][0])
                  + (SumWidth'(win[2][1]) << SOBEL_CENTRE_SHIFT)
                  + SumWidth'(bus.pixel_i);
        gx_next   = $signed({1'b0, gx_right})  - $signed({1'b0, gx_left});
        gy_next   = $signed({1'b0, gy_bottom}) - $signed({1'b0, gy_top});
    end

    // Output register: loads on an interior accept, drops on consume, holds under backpressure.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_q <= 1'b0;
            gx_q    <= '0;
            gy_q    <= '0;
        end else if (accept && out_cond) begin
            valid_q <= 1'b1;
            gx_q    <= gx_next;
            gy_q    <= gy_next;
        end else if (bus.ready_i) begin
            valid_q <= 1'b0;
        end
    end

    assign bus.valid_o = valid_q;
    assign bus.gx_o    = gx_q;
    assign bus.gy_o    = gy_q;

endmodule

// File: tb/tb_sobel_grad.sv
// Directed and randomised checks of sobel_grad on a 4x4 and an 8x6 image geometry.
module tb_sobel_grad;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    sobel_grad_if #(.PixelWidth(8)) bus_a ();
    sobel_grad_if #(.PixelWidth(8)) bus_b ();

    sobel_grad #(
        .PixelWidth (8),
        .ImgWidth   (4),
        .ImgHeight  (4)
    ) dut_a (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus_a)
    );

    sobel_grad #(
        .PixelWidth (8),
        .ImgWidth   (8),
        .ImgHeight  (6)
    ) dut_b (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus_b)
    );

    int checks = 0;
    int errors = 0;

    int got_gx_a[$];
    int got_gy_a[$];
    int got_gx_b[$];
    int got_gy_b[$];
    int exp_gx[$];
    int exp_gy[$];

    int img[];
    int img_b[];
    bit send_done;
    bit b_done;
    int held_gx;
    int held_gy;
    int guard;

    task automatic checkOutput(input string tag, input int observed, input int expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
        end
    endtask

    // Record every consumed output of each DUT.
    always @(negedge clk) begin
        if (bus_a.valid_o && bus_a.ready_i) begin
            got_gx_a.push_back(int'(bus_a.gx_o));
            got_gy_a.push_back(int'(bus_a.gy_o));
        end
        if (bus_b.valid_o && bus_b.ready_i) begin
            got_gx_b.push_back(int'(bus_b.gx_o));
            got_gy_b.push_back(int'(bus_b.gy_o));
        end
    end

    task automatic applyStimulusA(input int pix);
        int wait_cycles = 0;
        bus_a.valid_i = 1'b1;
        bus_a.pixel_i = 8'(pix);
        @(negedge clk);
        while (!bus_a.ready_o && wait_cycles < 200) begin
            @(negedge clk);
            wait_cycles++;
        end
        if (wait_cycles >= 200) checkOutput("accept_timeout_a", 0, 1);
        @(posedge clk);
        #1;
        bus_a.valid_i = 1'b0;
    endtask

    task automatic applyStimulusB(input int pix);
        int wait_cycles = 0;
        bus_b.valid_i = 1'b1;
        bus_b.pixel_i = 8'(pix);
        @(negedge clk);
        while (!bus_b.ready_o && wait_cycles < 200) begin
            @(negedge clk);
            wait_cycles++;
        end
        if (wait_cycles >= 200) checkOutput("accept_timeout_b", 0, 1);
        @(posedge clk);
        #1;
        bus_b.valid_i = 1'b0;
    endtask

    task automatic sendFrameA(input int frame[]);
        foreach (frame[i]) applyStimulusA(frame[i]);
    endtask

    task automatic waitCycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic fillConst(input int n, input int gx, input int gy);
        exp_gx.delete();
        exp_gy.delete();
        for (int i = 0; i < n; i++) begin
            exp_gx.push_back(gx);
            exp_gy.push_back(gy);
        end
    endtask

    // Reference: plain 2D Sobel over one frame stored at frame[base...], interior centres in raster order.
    task automatic buildExpected(input int frame[], input int base, input int w, input int h);
        int tl, tc, tr, ml, mr, bl, bc, br;
        for (int r = 1; r < h - 1; r++) begin
            for (int c = 1; c < w - 1; c++) begin
                tl = frame[base + (r - 1) * w + c - 1];
                tc = frame[base + (r - 1) * w + c];
                tr = frame[base + (r - 1) * w + c + 1];
                ml = frame[base + r * w + c - 1];
                mr = frame[base + r * w + c + 1];
                bl = frame[base + (r + 1) * w + c - 1];
                bc = frame[base + (r + 1) * w + c];
                br = frame[base + (r + 1) * w + c + 1];
                exp_gx.push_back((tr + 2 * mr + br) - (tl + 2 * ml + bl));
                exp_gy.push_back((bl + 2 * bc + br) - (tl + 2 * tc + tr));
            end
        end
    endtask

    task automatic compareA(input string tag);
        int n;
        checkOutput({tag, "_count"}, got_gx_a.size(), exp_gx.size());
        n = (got_gx_a.size() < exp_gx.size()) ? got_gx_a.size() : exp_gx.size();
        for (int i = 0; i < n; i++) begin
            checkOutput($sformatf("%s_gx%0d", tag, i), got_gx_a[i], exp_gx[i]);
            checkOutput($sformatf("%s_gy%0d", tag, i), got_gy_a[i], exp_gy[i]);
        end
        got_gx_a.delete();
        got_gy_a.delete();
    endtask

    task automatic compareB(input string tag);
        int n;
        checkOutput({tag, "_count"}, got_gx_b.size(), exp_gx.size());
        n = (got_gx_b.size() < exp_gx.size()) ? got_gx_b.size() : exp_gx.size();
        for (int i = 0; i < n; i++) begin
            checkOutput($sformatf("%s_gx%0d", tag, i), got_gx_b[i], exp_gx[i]);
            checkOutput($sformatf("%s_gy%0d", tag, i), got_gy_b[i], exp_gy[i]);
        end
        got_gx_b.delete();
        got_gy_b.delete();
    endtask

    // Safety net in case something stalls forever outside the bounded waits.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    // Main stimulus sequence.
    initial begin
        rst_n         = 1'b0;
        bus_a.valid_i = 1'b0;
        bus_a.pixel_i = '0;
        bus_a.ready_i = 1'b1;
        bus_b.valid_i = 1'b0;
        bus_b.pixel_i = '0;
        bus_b.ready_i = 1'b1;
        img = new[16];

        repeat (3) @(posedge clk);
        #2;
        checkOutput("rst_valid", int'(bus_a.valid_o), 0);
        checkOutput("rst_gx", int'(bus_a.gx_o), 0);
        checkOutput("rst_gy", int'(bus_a.gy_o), 0);
        checkOutput("rst_ready", int'(bus_a.ready_o), 1);
        checkOutput("rst_valid_b", int'(bus_b.valid_o), 0);
        rst_n = 1'b1;
        waitCycles(1);

        $display("[TB] flat frame");
        foreach (img[i]) img[i] = 100;
        sendFrameA(img);
        waitCycles(4);
        fillConst(4, 0, 0);
        compareA("flat");

        $display("[TB] vertical edge");
        foreach (img[i]) img[i] = ((i % 4) < 2) ? 0 : 255;
        sendFrameA(img);
        waitCycles(4);
        fillConst(4, 1020, 0);
        compareA("vedge");

        $display("[TB] mirrored vertical edge");
        foreach (img[i]) img[i] = ((i % 4) < 2) ? 255 : 0;
        sendFrameA(img);
        waitCycles(4);
        fillConst(4, -1020, 0);
        compareA("vedge_mirror");

        $display("[TB] horizontal edge");
        foreach (img[i]) img[i] = ((i / 4) < 2) ? 0 : 255;
        sendFrameA(img);
        waitCycles(4);
        fillConst(4, 0, 1020);
        compareA("hedge");

        $display("[TB] backpressure");
        foreach (img[i]) img[i] = (i * 37 + 11) % 256;
        exp_gx.delete();
        exp_gy.delete();
        buildExpected(img, 0, 4, 4);
        bus_a.ready_i = 1'b0;
        send_done = 1'b0;
        fork
            begin
                sendFrameA(img);
                send_done = 1'b1;
            end
        join_none
        guard = 0;
        @(negedge clk);
        while (!bus_a.valid_o && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        checkOutput("bp_valid_seen", int'(bus_a.valid_o), 1);
        held_gx = int'(bus_a.gx_o);
        held_gy = int'(bus_a.gy_o);
        checkOutput("bp_first_gx", held_gx, exp_gx[0]);
        checkOutput("bp_first_gy", held_gy, exp_gy[0]);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            checkOutput($sformatf("bp_ready_o%0d", k), int'(bus_a.ready_o), 0);
            checkOutput($sformatf("bp_valid_o%0d", k), int'(bus_a.valid_o), 1);
            checkOutput($sformatf("bp_hold_gx%0d", k), int'(bus_a.gx_o), held_gx);
            checkOutput($sformatf("bp_hold_gy%0d", k), int'(bus_a.gy_o), held_gy);
        end
        @(posedge clk);
        #1;
        bus_a.ready_i = 1'b1;
        guard = 0;
        while (!send_done && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        checkOutput("bp_send_done", int'(send_done), 1);
        waitCycles(4);
        compareA("bp");

        $display("[TB] reset with pending output");
        bus_a.ready_i = 1'b0;
        for (int i = 0; i < 11; i++) applyStimulusA((i * 20) % 256);
        waitCycles(1);
        checkOutput("rstp_pre_valid", int'(bus_a.valid_o), 1);
        rst_n = 1'b0;
        #2;
        checkOutput("rstp_valid", int'(bus_a.valid_o), 0);
        checkOutput("rstp_gx", int'(bus_a.gx_o), 0);
        checkOutput("rstp_gy", int'(bus_a.gy_o), 0);
        checkOutput("rstp_ready", int'(bus_a.ready_o), 1);
        bus_a.ready_i = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        waitCycles(1);
        got_gx_a.delete();
        got_gy_a.delete();

        $display("[TB] reset mid-frame then vertical edge");
        for (int i = 0; i < 6; i++) applyStimulusA(200);
        rst_n = 1'b0;
        #2;
        checkOutput("rstm_valid", int'(bus_a.valid_o), 0);
        @(negedge clk);
        rst_n = 1'b1;
        waitCycles(1);
        foreach (img[i]) img[i] = ((i % 4) < 2) ? 0 : 255;
        sendFrameA(img);
        waitCycles(4);
        fillConst(4, 1020, 0);
        compareA("rstm_frame");

        $display("[TB] random three frames 8x6");
        img_b = new[144];
        foreach (img_b[i]) img_b[i] = int'($urandom_range(0, 255));
        exp_gx.delete();
        exp_gy.delete();
        for (int f = 0; f < 3; f++) buildExpected(img_b, f * 48, 8, 6);
        got_gx_b.delete();
        got_gy_b.delete();
        b_done = 1'b0;
        fork
            begin
                while (!b_done) begin
                    @(posedge clk);
                    #1;
                    bus_b.ready_i = ($urandom_range(0, 3) != 0);
                end
                bus_b.ready_i = 1'b1;
            end
        join_none
        foreach (img_b[i]) begin
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk);
                #1;
            end
            applyStimulusB(img_b[i]);
        end
        b_done = 1'b1;
        guard = 0;
        while (got_gx_b.size() < 72 && guard < 500) begin
            @(negedge clk);
            guard++;
        end
        waitCycles(4);
        compareB("rand");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
